// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO.
// One operand bit is retired per RUN cycle. The operand magnitudes are processed
// unsigned, and the result signs are applied in a single FIX cycle at the end.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes allowed
// RUN   | WIDTH shift-add / shift-subtract iterations
// FIX   | sign correction, HI/LO write, done pulse next cycle
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic               op_div;
  logic               neg_lo;   // product or quotient must be negated
  logic               neg_hi;   // remainder must be negated (dividend was negative)
  logic               b_zero;
  logic [WIDTH-1:0]   a_keep;   // raw dividend, returned in HI on divide-by-zero
  logic [WIDTH-1:0]   mag_b;    // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;      // multiply: {partial, multiplier}; divide: {rem, quot}

  logic               accept;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign accept = (state == IDLE) && start;

  // Operand magnitudes; signed ops take absolute values (most negative maps to itself).
  always_comb begin
    a_abs = a;
    b_abs = b;
    if (op[0] && a[WIDTH-1]) a_abs = -a;
    if (op[0] && b[WIDTH-1]) b_abs = -b;
  end

  // One iteration of radix-2 shift-add and of restoring shift-subtract.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_trial = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_trial - {1'b0, mag_b};
    if (div_diff[WIDTH])
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction of the finished magnitudes.
  always_comb begin
    prod_fix = acc;
    quot_fix = acc[WIDTH-1:0];
    rem_fix  = acc[2*WIDTH-1:WIDTH];
    if (neg_lo) begin
      prod_fix = -acc;
      quot_fix = -acc[WIDTH-1:0];
    end
    if (neg_hi) rem_fix = -acc[2*WIDTH-1:WIDTH];
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      op_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      b_zero <= 1'b0;
      a_keep <= '0;
      mag_b  <= '0;
      acc    <= '0;
    end else if (accept) begin
      cnt    <= '0;
      op_div <= op[1];
      neg_lo <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi <= op[0] & a[WIDTH-1];
      b_zero <= (b == '0);
      a_keep <= a;
      mag_b  <= b_abs;
      acc    <= {{WIDTH{1'b0}}, a_abs};
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      acc <= op_div ? div_next : mul_next;
    end
  end

  // Architectural HI/LO: written on FIX, or by MTHI/MTLO while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX) begin
      if (!op_div) begin
        {hi, lo} <= prod_fix;
      end else if (b_zero) begin
        hi <= a_keep;
        lo <= '1;
      end else begin
        hi <= rem_fix;
        lo <= quot_fix;
      end
    end else if (state == IDLE) begin
      if (wr_hi) hi <= wd;
      if (wr_lo) lo <= wd;
    end
  end

  // Registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      div0 <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state == FIX);
      div0 <= (state == FIX) && op_div && b_zero;
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width. It sits beside the ALU in the next-generation MIPS datapath and executes MULT, MULTU, DIV and DIVU over multiple cycles, one operand bit per cycle. The datapath sees a start/busy/done handshake, and the core stalls on `busy` when reading HI/LO. MTHI/MTLO writes go to the same registers.

## Interface
- WIDTH, 32, operand width and width of HI and LO; legal range is WIDTH ≥ 2.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request an operation; accepted only when busy=0.
- op  in  2  operation code: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed); sampled with start.
- a  in  WIDTH  multiplicand or dividend; sampled with start.
- b  in  WIDTH  multiplier or divisor; sampled with start.
- wr_hi  in  1  write wd into HI (MTHI).
- wr_lo  in  1  write wd into LO (MTLO).
- wd  in  WIDTH  write data for HI/LO.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div0  out  1  qualifies done: the completed division had b=0.
- hi  out  WIDTH  HI register: product upper half, or remainder.
- lo  out  WIDTH  LO register: product lower half, or quotient.

## Operation
- FSM states: IDLE, RUN, FIX.
  - IDLE→RUN on a rising edge with start=1. On that edge, latch op and the operand magnitudes (absolute values if op[0]=1). Also record the result signs and clear the iteration counter.
  - RUN lasts exactly WIDTH cycles. The counter is $clog2(WIDTH+1) bits and increments once per RUN edge.
    - Multiply: radix-2 shift-add into a 2·WIDTH accumulator.
    - Divide: restoring shift-subtract producing quotient and remainder.
  - RUN→FIX when the counter reaches WIDTH-1.
  - FIX→IDLE after one cycle. On the FIX edge: apply sign correction, write HI/LO, set done=1 for one cycle and clear busy.
- Signed multiply: {hi,lo} = full 2·WIDTH two's-complement product.
- Unsigned multiply: {hi,lo} = full 2·WIDTH unsigned product.
- Signed divide:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Overflow case (most negative value divided by -1): lo = most negative value, hi = 0, no flag.
- Divide by zero, b=0, for DIV or DIVU:
  - Result: lo = all ones, hi = a as sampled, not sign-corrected.
  - div0=1 together with done.
  - Latency is the same as a normal divide.
- div0 is 0 whenever done=0, and 0 for all multiplies.
- start while busy=1 is ignored; it is not queued.
- MTHI/MTLO:
  - wr_hi/wr_lo take effect on the edge only when busy=0.
  - They are ignored while busy=1.
  - They may coincide with an accepted start. The write lands, and the later FIX write overwrites it.
- hi/lo are stable during RUN; they change only on a FIX edge, a reset, or an MTHI/MTLO write.
- Reset (asynchronous, any state including mid-RUN):
  - State → IDLE; the in-flight operation is discarded.
  - hi=0, lo=0, busy=0, done=0, div0=0, counter=0.

## Timing
- Edge 0 accepts start. busy=1 from immediately after edge 0 until after edge WIDTH+1.
- Edge WIDTH+1 (the FIX edge) updates HI/LO. In the following cycle, done=1 and busy=0.
- Latency: WIDTH+1 edges from accepted start to result; 33 for WIDTH=32.
- Back-to-back operation: start may be asserted in the done cycle and is accepted on that cycle's edge. Maximum throughput is one operation per WIDTH+2 cycles.
- Outputs are registered; no combinational path exists from any input to any output.
- a, b and op may change freely after the accepting edge.

## Test plan
- MULTU, WIDTH=32, a=b=0xFFFFFFFF.
  - Expect hi=0xFFFFFFFE, lo=0x00000001.
  - done exactly 33 edges after start; busy high for 33 cycles.
- MULT -3×7.
  - Expect hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7÷2.
  - Expect lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000÷0xFFFFFFFF.
  - Expect lo=0x80000000, hi=0, div0=0.
- DIVU 100÷0.
  - Expect lo=0xFFFFFFFF, hi=100, div0=1 only in the done cycle.
- Control cases:
  - start pulsed mid-RUN with different operands: the result matches the first operation only, with no second done.
  - wr_hi mid-RUN: ignored.
  - MTLO 0x1234 while idle: lo=0x1234 next cycle.
  - reset low at RUN cycle 10: all outputs 0 immediately, and a new start afterwards completes normally.
  - Repeat with WIDTH=8: 0xFF×0xFF signed gives hi=0x00, lo=0x01; done after 9 edges.
